exer_sweep_checker: RTL
=======================

Name: exer_sweep_checker

Overview:
Self-checking exhaustive stimulus/response engine for the 4-input, 2-output gate-level exercise function (F1 = x1 + x2·x4' + x3·x4'; F2 = (x1+x2+x4)(x1+x3'+x4')). It drives every input vector onto the function under test and samples the F response. It compares that response against a built-in golden truth table, counts mismatches and reports pass/fail through a start/done handshake. It is the response-side counterpart to the free-running display benches and lets exercise models be checked in simulation or on a board.

Parameters:
N_IN, 4, input vector width; 2**N_IN vectors swept
N_OUT, 2, response width
SETTLE, 1, cycles between driving x and sampling f; legal range 1..15
EXP_F1, 16'hFF54, golden F1; bit v = expected F1 for vector value v
EXP_F2, 16'hFF72, golden F2; bit v = expected F2 for vector value v

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  sweep request; sampled only in IDLE
x  output  [1:N_IN]  stimulus; x[1] = MSB of vector index
f  input  [1:N_OUT]  response from the function under test; f[1]=F1, f[2]=F2
busy  output  1  high from the cycle after start is accepted until the DONE cycle
done  output  1  one-cycle pulse at end of sweep
pass  output  1  1 when err_count==0; valid from done until the next accepted start
err_count  output  N_IN+1  number of mismatching vectors, 0..16
first_fail_idx  output  N_IN  index of the first mismatching vector
first_fail_valid  output  1  high when at least one mismatch is recorded

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. Everything updates on the rising edge of clk.
- Reset values: state=IDLE, x=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, first_fail_valid=0, idx=0, settle counter=0.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE: when start=1, load idx=0, x=0 and settle count=SETTLE-1. Clear err_count, first_fail_* and pass. Go to DRIVE and set busy=1.
- DRIVE: x holds idx. Decrement the settle count; when it is 0, go to CHECK.
- CHECK: sample f and compare it with {EXP_F1[idx], EXP_F2[idx]}.
  - On mismatch, increment err_count. If first_fail_valid=0, set it to 1 and capture first_fail_idx=idx.
  - If idx==2**N_IN-1, go to DONE. Otherwise idx+1 -> idx and x, reload the settle count and go to DRIVE.
- Vector timing: each vector occupies SETTLE+1 cycles. With defaults the full sweep is 32 cycles from the start-accept edge to the DONE cycle.
- DONE (one cycle): done=1, busy=0, pass=(err_count==0), x returns to 0, then go to IDLE. pass, err_count and first_fail_* hold until the next accepted start.
- start while busy or in DONE: ignored. A start held high restarts the sweep only once the FSM is back in IDLE.
- Compare rule: any f bit not equal to the golden bit is a mismatch, including X/Z in simulation (case-inequality).
- Counter behaviour: err_count cannot overflow, since its maximum is 16 in N_IN+1 bits. idx does not wrap inside a sweep.
- Reset mid-sweep: aborts immediately to the reset values. No done pulse is produced.

Decomposition:
- Shared package exer_pkg holds the state enum (IDLE/DRIVE/CHECK/DONE) and the golden constants EXP_F1 and EXP_F2, so other exercise checkers reuse the same pattern.
- One sub-module: exer_golden_rom. It takes idx and returns the expected N_OUT-bit vector from the parameters, keeping the FSM independent of the function being checked.

Test Plan:
- Loop f from the real exercise gate model, defaults -> done 32 cycles after start; pass=1, err_count=0, first_fail_valid=0.
- f tied 2'b11 -> err_count=6, first_fail_idx=0, pass=0 (matches only at v=4, 6, 8..15).
- f tied 2'b00 -> err_count=13, first_fail_idx=1 (matches only at v=0, 3, 7).
- Gate model with F2 inverted only at x=4'b1011 -> err_count=1, first_fail_idx=11, first_fail_valid=1.
- rst asserted while x=4'b0101 -> next edge: x=0, busy=0, err_count=0, no done. A new start then completes a clean 32-cycle sweep. start pulses during busy and during the DONE cycle are ignored.
- SETTLE=3, correct model -> done 64 cycles after start; each x value is held for 4 cycles; pass=1.

Source files
------------

// File: rtl/exer_pkg.sv
// Shared types and golden tables for the gate-level exercise checkers.
// F1 = x1 + x2.x4' + x3.x4' ; F2 = (x1+x2+x4)(x1+x3'+x4'), bit v = response to vector v.
package exer_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam int N_IN_DEF   = 4;
  localparam int N_OUT_DEF  = 2;
  localparam int SETTLE_DEF = 1;

  localparam logic [15:0] EXP_F1 = 16'hFF54;
  localparam logic [15:0] EXP_F2 = 16'hFF72;

endpackage

// File: rtl/exer_sweep_checker_if.sv
// Stimulus/response and result bundle between the sweep checker and its surroundings.
// master = checker side (drives x and results), slave = function-under-test / controller side.
interface exer_sweep_checker_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
);
  logic             start;
  logic [N_IN-1:0]  x;
  logic [N_OUT-1:0] f;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    err_count;
  logic [N_IN-1:0]  first_fail_idx;
  logic             first_fail_valid;

  modport master (
    input  start, f,
    output x, busy, done, pass, err_count, first_fail_idx, first_fail_valid
  );

  modport slave (
    output start, f,
    input  x, busy, done, pass, err_count, first_fail_idx, first_fail_valid
  );
endinterface

// File: rtl/exer_golden_rom.sv
// Expected response lookup: returns {F1, F2} golden bits for vector idx, combinational.
// No state and no flow control; the FSM simply indexes it with its current vector.
module exer_golden_rom #(
  parameter int                 N_IN   = 4,
  parameter int                 N_OUT  = 2,
  parameter logic [2**N_IN-1:0] EXP_F1 = exer_pkg::EXP_F1,
  parameter logic [2**N_IN-1:0] EXP_F2 = exer_pkg::EXP_F2
) (
  input  logic [N_IN-1:0]  idx,
  output logic [N_OUT-1:0] exp_f
);

  // MSB carries F1 so the vector lines up with f (F1 in the upper bit).
  assign exp_f = N_OUT'({EXP_F1[idx], EXP_F2[idx]});

endmodule

// File: rtl/exer_sweep_checker.sv
// Exhaustive sweep of all 2**N_IN vectors against the golden table; SETTLE+1 cycles per vector.
// start is only honoured in IDLE; requests while busy or in the done cycle are dropped.
module exer_sweep_checker #(
  parameter int                 N_IN   = exer_pkg::N_IN_DEF,
  parameter int                 N_OUT  = exer_pkg::N_OUT_DEF,
  parameter int                 SETTLE = exer_pkg::SETTLE_DEF,
  parameter logic [2**N_IN-1:0] EXP_F1 = exer_pkg::EXP_F1,
  parameter logic [2**N_IN-1:0] EXP_F2 = exer_pkg::EXP_F2
) (
  input logic                 clk,
  input logic                 rst,
  exer_sweep_checker_if.master bus
);
  import exer_pkg::*;

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE - 1);

  state_t           state;
  logic [N_IN-1:0]  idx;
  logic [3:0]       settle_cnt;
  logic [N_OUT-1:0] exp_f;
  logic             mismatch;
  logic [N_IN:0]    err_next;

  exer_golden_rom #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .EXP_F1 (EXP_F1),
    .EXP_F2 (EXP_F2)
  ) u_rom (
    .idx   (idx),
    .exp_f (exp_f)
  );

  // Case-inequality so an X/Z response from the model counts as a failure.
  assign mismatch = (bus.f !== exp_f);
  assign err_next = bus.err_count + {{N_IN{1'b0}}, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      idx                  <= '0;
      settle_cnt           <= '0;
      bus.x                <= '0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.pass             <= 1'b0;
      bus.err_count        <= '0;
      bus.first_fail_idx   <= '0;
      bus.first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            idx                  <= '0;
            bus.x                <= '0;
            settle_cnt           <= SETTLE_RELOAD;
            bus.err_count        <= '0;
            bus.first_fail_idx   <= '0;
            bus.first_fail_valid <= 1'b0;
            bus.pass             <= 1'b0;
            bus.busy             <= 1'b1;
            state                <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == '0) state <= CHECK;
          else                  settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          bus.err_count <= err_next;
          if (mismatch && !bus.first_fail_valid) begin
            bus.first_fail_valid <= 1'b1;
            bus.first_fail_idx   <= idx;
          end
          if (idx == '1) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            bus.pass <= (err_next == '0);
            bus.x    <= '0;
            state    <= DONE;
          end else begin
            idx        <= idx + 1'b1;
            bus.x      <= idx + 1'b1;
            settle_cnt <= SETTLE_RELOAD;
            state      <= DRIVE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
